// File: rtl/tdc_sum_pkg.sv
// Shared TDC package: default sizing for the sum scheduler and its FSM states.
package tdc_sum_pkg;

  localparam int TDC_CHANNELS = 4;
  localparam int TDC_INPUTS   = 4;
  localparam int TDC_BITS     = 3;
  localparam int TDC_SUM_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

endpackage

// File: rtl/tdc_sum_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping,
// and returns the first requester as a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any_req
);

  int cand;

  // Walk the candidates farthest-first so the one nearest ptr is written last and wins.
  always_comb begin
    grant   = '0;
    index   = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        index   = IDX_W'(cand);
        any_req = 1'b1;
      end
    end
    if (enable && any_req) begin
      grant[index] = 1'b1;
    end
  end

endmodule

// File: rtl/tdc_sum_scheduler.sv
// Time-shares the single TDC adder tree among channels: round-robin grant,
// register the chosen vector onto the tree, capture the sum, hand it out.
module tdc_sum_scheduler
  import tdc_sum_pkg::*;
#(
  parameter int CHANNELS = TDC_CHANNELS,
  parameter int INPUTS   = TDC_INPUTS,
  parameter int BITS     = TDC_BITS,
  parameter int SUM_W    = TDC_SUM_W,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             req_valid,
  input  logic [CHANNELS*INPUTS*BITS-1:0] req_data,
  output logic [CHANNELS-1:0]             req_ready,
  output logic [INPUTS*BITS-1:0]          tree_x,
  input  logic [SUM_W-1:0]                tree_y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SUM_W-1:0]                out_sum,
  output logic [CH_W-1:0]                 out_chan
);

  localparam int VEC_W = INPUTS * BITS;

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [VEC_W-1:0]  tree_x_q, tree_x_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [CH_W-1:0]   out_chan_q, out_chan_d;
  logic              out_valid_q, out_valid_d;

  logic                grant_en;
  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     grant_idx;
  logic                any_req;
  logic                grant_fire;

  // Grants are offered only when idle or when the held result is being taken;
  // rst_n gates it so nothing is acknowledged while reset is asserted.
  assign grant_en   = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign grant_fire = |grant;

  rr_arbiter #(
    .N     (CHANNELS),
    .IDX_W (CH_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .enable  (grant_en),
    .grant   (grant),
    .index   (grant_idx),
    .any_req (any_req)
  );

  assign req_ready = grant;
  assign tree_x    = tree_x_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_chan  = out_chan_q;

  // Next-state logic: load a granted vector, capture the tree sum, hold for handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    chan_d      = chan_q;
    tree_x_d    = tree_x_q;
    out_sum_d   = out_sum_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        out_sum_d   = tree_y;
        out_chan_d  = chan_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = grant_fire ? EVAL : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_fire) begin
      tree_x_d = req_data[int'(grant_idx) * VEC_W +: VEC_W];
      chan_d   = grant_idx;
      ptr_d    = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // State and datapath registers; reset abandons any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      chan_q      <= '0;
      tree_x_q    <= '0;
      out_sum_q   <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      chan_q      <= chan_d;
      tree_x_q    <= tree_x_d;
      out_sum_q   <= out_sum_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_tdc_sum_scheduler.sv
// Bench for tdc_sum_scheduler: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the scheduling rules.
module tb_tdc_sum_scheduler;

   localparam int C  = 4;
   localparam int I  = 4;
   localparam int B  = 3;
   localparam int S  = 5;
   localparam int CW = 2;
   localparam int VW = I * B;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [C-1:0]    req_valid;
   logic [C*VW-1:0] req_data;
   logic [C-1:0]    req_ready;
   logic [VW-1:0]   tree_x;
   logic [S-1:0]    tree_y;
   logic            out_valid;
   logic            out_ready;
   logic [S-1:0]    out_sum;
   logic [CW-1:0]   out_chan;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   // Model of the scheduler: phase 0 = idle, 1 = evaluating, 2 = holding a result
   int            mPhase;
   int            mPtr;
   int            mValid;
   int            mSum;
   int            mChan;
   int            pendSum;
   int            pendChan;
   logic [VW-1:0] mTreeX;
   logic [C-1:0]  lastGrant;

   // Free-running clock
   always #5 clk = ~clk;

   tdc_sum_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tree_x    (tree_x),
      .tree_y    (tree_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_chan  (out_chan)
   );

   // Stand-in for the external adder tree sitting next to the scheduler
   always_comb begin
      tree_y = '0;
      for (int i = 0; i < I; i++) tree_y = tree_y + S'(tree_x[i*B +: B]);
   end

   function automatic int fieldSum(logic [VW-1:0] v);
      int s = 0;
      for (int i = 0; i < I; i++) s += int'(v[i*B +: B]);
      return s;
   endfunction

   function automatic int pick(logic [C-1:0] rv, int ptr);
      for (int k = 0; k < C; k++) begin
         if (rv[(ptr + k) % C]) return (ptr + k) % C;
      end
      return -1;
   endfunction

   function automatic logic [VW-1:0] vec(int a, int b, int c, int d);
      return {B'(d), B'(c), B'(b), B'(a)};
   endfunction

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mPhase   = 0;
      mPtr     = 0;
      mValid   = 0;
      mSum     = 0;
      mChan    = 0;
      pendSum  = 0;
      pendChan = 0;
      mTreeX   = '0;
   endtask

   // One clock cycle: check outputs against the model, then advance the model at the edge
   task automatic runCycle();
      int           g;
      bit           can;
      logic [C-1:0] expReady;
      #1;
      can      = (mPhase == 0) || (mPhase == 2 && out_ready);
      g        = pick(req_valid, mPtr);
      expReady = '0;
      if (can && g >= 0) expReady[g] = 1'b1;
      lastGrant = expReady;
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("out_sum",   32'(out_sum),   32'(mSum));
      checkOutput("out_chan",  32'(out_chan),  32'(mChan));
      checkOutput("tree_x",    32'(tree_x),    32'(mTreeX));
      @(posedge clk);
      if (mPhase == 1) begin
         mSum   = pendSum;
         mChan  = pendChan;
         mValid = 1;
         mPhase = 2;
      end else if (can && g >= 0) begin
         mTreeX   = req_data[g*VW +: VW];
         pendSum  = fieldSum(mTreeX) % (1 << S);
         pendChan = g;
         mPtr     = (g + 1) % C;
         mValid   = 0;
         mPhase   = 1;
      end else if (mPhase == 2 && out_ready) begin
         mValid = 0;
         mPhase = 0;
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(logic [C-1:0] v, logic r);
      req_valid = v;
      out_ready = r;
      runCycle();
   endtask

   // Asynchronous reset pulse from a negedge; outputs must drop before any clock edge
   task automatic doReset();
      req_valid = '1;
      rst_n     = 1'b0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_tree_x",    32'(tree_x),    32'd0);
      checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watchdog so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b0001;
      out_ready = 1'b1;
      req_data  = '0;
      req_data[0 +: VW] = vec(1, 2, 3, 4);
      lastGrant = '0;
      resetModel();

      // Reset state
      @(negedge clk);
      #1;
      checkOutput("init_req_ready", 32'(req_ready), 32'd0);
      checkOutput("init_out_valid", 32'(out_valid), 32'd0);
      checkOutput("init_tree_x",    32'(tree_x),    32'd0);
      checkOutput("init_out_chan",  32'(out_chan),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request from ch0 with fields 1,2,3,4
      applyStimulus(4'b0001, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_out_sum",   32'(out_sum),   32'd10);
      checkOutput("t1_out_chan",  32'(out_chan),  32'd0);
      applyStimulus(4'b0000, 1'b1);

      // All channels requesting continuously
      for (int c = 0; c < C; c++) req_data[c*VW +: VW] = VW'($urandom);
      for (int n = 0; n < 16; n++) begin
         applyStimulus(4'b1111, 1'b1);
         for (int c = 0; c < C; c++)
            if (lastGrant[c]) req_data[c*VW +: VW] = VW'($urandom);
      end

      // Stall the output for five cycles while holding a result
      for (int k = 0; k < 4 && mPhase != 2; k++) applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) applyStimulus(4'b1111, 1'b0);

      // Back-to-back grants to ch2 from HOLD
      req_data[2*VW +: VW] = vec(7, 7, 7, 7);
      applyStimulus(4'b0100, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t4_out_sum", 32'(out_sum), 32'd28);
      req_data[2*VW +: VW] = vec(0, 5, 0, 6);
      applyStimulus(4'b0100, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t4_out_sum2", 32'(out_sum), 32'd11);

      // Pointer at 3 with requests from ch0 and ch3: ch3 then ch0
      req_data[3*VW +: VW] = vec(1, 1, 1, 1);
      req_data[0*VW +: VW] = vec(2, 0, 0, 0);
      applyStimulus(4'b1001, 1'b1);
      applyStimulus(4'b0001, 1'b1);
      checkOutput("t5_first_chan", 32'(out_chan), 32'd3);
      checkOutput("t5_first_sum",  32'(out_sum),  32'd4);
      applyStimulus(4'b0001, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t5_second_chan", 32'(out_chan), 32'd0);
      checkOutput("t5_second_sum",  32'(out_sum),  32'd2);
      applyStimulus(4'b0000, 1'b1);

      // Reset during EVAL, then during HOLD
      applyStimulus(4'b1111, 1'b1);
      doReset();
      applyStimulus(4'b1111, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      doReset();
      applyStimulus(4'b1111, 1'b1);

      // Random traffic with requesters that hold data until granted
      for (int n = 0; n < 400; n++) begin
         logic [C-1:0] v;
         v = req_valid;
         for (int c = 0; c < C; c++) begin
            if (lastGrant[c] || !v[c]) begin
               v[c] = ($urandom_range(0, 2) != 0);
               req_data[c*VW +: VW] = VW'($urandom);
            end
         end
         applyStimulus(v, ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
